// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer: op encodings, FSM states, slice width.
package alu_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice. SUB is treated as ADD here; the caller supplies ~b and cin=1.
module alu_nibble_slice
   import alu_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  op_e                 op,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] f,
   output logic                cout,
   output logic                c3
);

   logic [3:0] lo_sum;
   logic [1:0] hi_sum;

   // Split at bit 3 so the carry into the MSB is visible for signed overflow.
   always_comb begin
      lo_sum = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
      hi_sum = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo_sum[3]};
      f      = '0;
      cout   = 1'b0;
      c3     = 1'b0;
      case (op)
         OP_AND: f = a & b;
         OP_OR:  f = a | b;
         default: begin
            f    = {hi_sum[0], lo_sum[2:0]};
            cout = hi_sum[1];
            c3   = lo_sum[3];
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Two-requester arbiter and nibble-serial sequencer around one 4-bit ALU slice.
// Optional `ALU_SEQ_PERF_EN adds the perf_ops completed-handshake counter.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter  int WORDS = 2,
   localparam int W     = NIBBLE_W * WORDS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [1:0]    req0_op,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [1:0]    req1_op,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [W-1:0]  rsp_result,
   output logic          rsp_zero,
   output logic          rsp_cout,
   output logic          rsp_overflow,
   output logic          busy
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [15:0]   perf_ops
`endif
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [WORDS-1:0][NIBBLE_W-1:0] word_t;

   state_e state_q, state_d;
   op_e    op_q, op_d;
   word_t  a_q, a_d, b_q, b_d, result_q, result_d;
   idx_t   idx_q, idx_d;
   logic   id_q, id_d, last_grant_q, last_grant_d, carry_q, carry_d;
   logic   rsp_valid_q, rsp_valid_d, zero_q, zero_d;
   logic   cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0] perf_q, perf_d;
`endif

   logic                grant0, grant1, arith;
   logic [NIBBLE_W-1:0] slice_a, slice_b, slice_f;
   logic                slice_cout, slice_c3;

   assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
   assign slice_a = a_q[idx_q];
   assign slice_b = (op_q == OP_SUB) ? ~b_q[idx_q] : b_q[idx_q];

   alu_nibble_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .op   (op_q),
      .cin  (carry_q),
      .f    (slice_f),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   // Round-robin: on contention the requester that did not win last time goes first.
   assign grant0     = req0_valid && (!req1_valid || last_grant_q);
   assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
   assign req0_ready = (state_q == ST_IDLE) && grant0;
   assign req1_ready = (state_q == ST_IDLE) && grant1;

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      idx_d        = idx_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      carry_d      = carry_q;
      rsp_valid_d  = rsp_valid_q;
      zero_d       = zero_q;
      cout_d       = cout_q;
      ovf_d        = ovf_q;
`ifdef ALU_SEQ_PERF_EN
      perf_d       = perf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant0 || grant1) begin
               id_d         = grant1;
               last_grant_d = grant1;
               op_d         = grant1 ? op_e'(req1_op) : op_e'(req0_op);
               a_d          = grant1 ? req1_a : req0_a;
               b_d          = grant1 ? req1_b : req0_b;
               idx_d        = '0;
               carry_d      = grant1 ? (req1_op == OP_SUB) : (req0_op == OP_SUB);
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d[idx_q] = slice_f;
            carry_d         = arith & slice_cout;
            if (idx_q == idx_t'(WORDS - 1)) begin
               cout_d      = arith & slice_cout;
               ovf_d       = arith & (slice_c3 ^ slice_cout);
               zero_d      = (result_d == '0);
               rsp_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q + idx_t'(1);
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
`ifdef ALU_SEQ_PERF_EN
               perf_d      = perf_q + 16'd1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_AND;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         idx_q        <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         carry_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         zero_q       <= 1'b0;
         cout_q       <= 1'b0;
         ovf_q        <= 1'b0;
         busy_q       <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
         perf_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         idx_q        <= idx_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         carry_q      <= carry_d;
         rsp_valid_q  <= rsp_valid_d;
         zero_q       <= zero_d;
         cout_q       <= cout_d;
         ovf_q        <= ovf_d;
         busy_q       <= busy_d;
`ifdef ALU_SEQ_PERF_EN
         perf_q       <= perf_d;
`endif
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = id_q;
   assign rsp_result   = result_q;
   assign rsp_zero     = zero_q;
   assign rsp_cout     = cout_q;
   assign rsp_overflow = ovf_q;
   assign busy         = busy_q;
`ifdef ALU_SEQ_PERF_EN
   assign perf_ops     = perf_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (WORDS=2): vector table plus arbitration, stall and reset sequences.
// With ALU_SEQ_PERF_EN defined, perf_ops is compared against the observed handshake count.
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   localparam int WORDS = 2;
   localparam int W     = 4 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid, rsp_ready;
   logic         req0_ready, req1_ready;
   logic [1:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_id, rsp_zero, rsp_cout, rsp_overflow, busy;
   logic [W-1:0] rsp_result;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0]  perf_ops;
`endif

   typedef struct {
      logic         id;
      logic [W-1:0] result;
      logic         zero;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic         id;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] result;
      logic         zero;
      logic         cout;
      logic         ovf;
   } vec_t;

   exp_t expQ[$];
   int   errors     = 0;
   int   checks     = 0;
   int   handshakes = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_cout     (rsp_cout),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
`ifdef ALU_SEQ_PERF_EN
      ,
      .perf_ops     (perf_ops)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out waiting, expected event within bound at %0t", name, $time);
   endtask

   // Scoreboard consumer: every completed response must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         checkOutput("single_ready", 32'(req0_ready & req1_ready), 32'(0));
         if (rsp_valid && rsp_ready) begin
            handshakes++;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rsp: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
            end else begin
               e = expQ.pop_front();
               checkOutput("rsp_id",       32'(rsp_id),       32'(e.id));
               checkOutput("rsp_result",   32'(rsp_result),   32'(e.result));
               checkOutput("rsp_zero",     32'(rsp_zero),     32'(e.zero));
               checkOutput("rsp_cout",     32'(rsp_cout),     32'(e.cout));
               checkOutput("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
            end
         end
      end
   end

   task automatic driveReq(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   task automatic dropReq(input logic id);
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic pushExp(input logic id, input logic [W-1:0] r, input logic z, input logic c, input logic v);
      exp_t e;
      e = '{id: id, result: r, zero: z, cout: c, ovf: v};
      expQ.push_back(e);
   endtask

   task automatic waitReady(input logic id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail(id ? "wait_req1_ready" : "wait_req0_ready");
   endtask

   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy && expQ.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) timeoutFail("wait_idle");
   endtask

   // One transaction: drive, wait for grant, measure accept-to-valid latency, drain.
   task automatic applyStimulus(input vec_t v);
      bit ok;
      int lat;
      @(posedge clk); #1;
      driveReq(v.id, v.op, v.a, v.b);
      waitReady(v.id, ok);
      if (ok) begin
         pushExp(v.id, v.result, v.zero, v.cout, v.ovf);
         @(posedge clk); #1;
         dropReq(v.id);
         lat = 1;
         while (lat < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            lat++;
         end
         checkOutput("latency", 32'(lat), 32'(WORDS + 1));
      end else begin
         dropReq(v.id);
      end
      waitIdle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[10];
      bit   ok;
      int   savedHs;
      int   seen;

      vecs[0] = '{1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b1, OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{1'b0, OP_AND, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, OP_OR,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, OP_AND, 8'h5A, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b1, OP_ADD, 8'h3C, 8'h4B, 8'h87, 1'b0, 1'b0, 1'b1};

      rst_n      = 1'b0;
      req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
      rsp_ready  = 1'b1;
      #12;
      checkOutput("reset_rsp_valid",  32'(rsp_valid),    32'(0));
      checkOutput("reset_busy",       32'(busy),         32'(0));
      checkOutput("reset_rsp_result", 32'(rsp_result),   32'(0));
      checkOutput("reset_rsp_id",     32'(rsp_id),       32'(0));
      checkOutput("reset_flags",      32'({rsp_zero, rsp_cout, rsp_overflow}), 32'(0));
      checkOutput("reset_readies",    32'({req0_ready, req1_ready}), 32'(0));
`ifdef ALU_SEQ_PERF_EN
      checkOutput("reset_perf_ops",   32'(perf_ops),     32'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] contention out of reset");
      @(posedge clk); #1;
      driveReq(1'b0, OP_AND, 8'hF0, 8'h3C);
      driveReq(1'b1, OP_OR,  8'h0F, 8'hF0);
      pushExp(1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
      pushExp(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      waitReady(1'b0, ok);
      checkOutput("arb_first_req1_ready", 32'(req1_ready), 32'(0));
      @(posedge clk); #1;
      dropReq(1'b0);
      waitReady(1'b1, ok);
      @(posedge clk); #1;
      dropReq(1'b1);
      waitIdle();

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

      $display("[TB] response back-pressure");
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      driveReq(1'b0, OP_ADD, 8'h12, 8'h34);
      waitReady(1'b0, ok);
      pushExp(1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      dropReq(1'b0);
      driveReq(1'b1, OP_SUB, 8'h10, 8'h01);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1;
            break;
         end
      end
      if (seen == 0) timeoutFail("stall_wait_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_rsp_valid",  32'(rsp_valid),  32'(1));
         checkOutput("stall_rsp_result", 32'(rsp_result), 32'(8'h46));
         checkOutput("stall_rsp_id",     32'(rsp_id),     32'(0));
         checkOutput("stall_busy",       32'(busy),       32'(1));
         checkOutput("stall_readies",    32'({req0_ready, req1_ready}), 32'(0));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_busy",      32'(busy),      32'(0));
      checkOutput("release_rsp_valid", 32'(rsp_valid), 32'(0));
      waitReady(1'b1, ok);
      pushExp(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      dropReq(1'b1);
      waitIdle();

      $display("[TB] reset during execution");
      @(posedge clk); #1;
      driveReq(1'b0, OP_ADD, 8'h11, 8'h22);
      waitReady(1'b0, ok);
      @(posedge clk); #1;
      dropReq(1'b0);
      checkOutput("exec_busy", 32'(busy), 32'(1));
      #2;
      rst_n = 1'b0;
      handshakes = 0;
      #1;
      checkOutput("async_reset_busy",      32'(busy),      32'(0));
      checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      savedHs = handshakes;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) seen = 1;
      end
      checkOutput("no_rsp_after_reset", 32'(seen), 32'(0));
      checkOutput("no_handshake_after_reset", 32'(handshakes), 32'(savedHs));
      applyStimulus('{1'b0, OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0});

`ifdef ALU_SEQ_PERF_EN
      checkOutput("perf_ops", 32'(perf_ops), 32'(handshakes));
`endif
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer and arbiter for the nibble-wide ALU datapath. Two requesters share one 4-bit ALU slice. The controller accepts one operation at a time and runs it over WORDS nibbles, LSB nibble first, carrying between nibbles in a register. It returns the result with zero, carry and overflow flags over a valid/ready response channel.

Parameters:
WORDS, 2, number of 4-bit nibbles per operand; operand width W = 4*WORDS; legal range 1..8.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
req0_a  in  W  operand A
req0_b  in  W  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the operation
rsp_result  out  W  result
rsp_zero  out  1  rsp_result == 0
rsp_cout  out  1  carry out of MSB nibble (ADD/SUB only, else 0)
rsp_overflow  out  1  signed overflow = carry into MSB bit XOR carry out of MSB bit (ADD/SUB only, else 0)
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, DONE. Reset value: IDLE.
- Reset values: all outputs 0; result register 0; nibble index 0; round-robin pointer last_grant = 1.
- IDLE arbitration:
  - Single valid requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready is combinational: (state == IDLE) && grantN. At most one ready is high per cycle.
- Accept edge: capture op, a, b and id; last_grant <= id; idx <= 0; carry <= (op == SUB); go to EXEC.
- EXEC, one nibble per cycle:
  - Slice inputs: a[idx], b[idx] (inverted when op is SUB), carry-in from the carry register.
  - Store the slice output in result[idx]; carry <= slice cout (ADD/SUB).
  - On idx == WORDS-1: latch cout and overflow (from the MSB bit's carry-in/carry-out), compute zero, go to DONE. Otherwise idx++.
- DONE:
  - rsp_valid = 1; all rsp_* outputs stable until rsp_ready.
  - rsp_valid && rsp_ready: go to IDLE. The next accept occurs no earlier than the following cycle.
- Latency: accept at edge T; rsp_valid high from cycle T+WORDS+1. Minimum throughput is one operation per WORDS+2 cycles.
- Requests are ignored while not in IDLE. Requesters hold valid and fields stable until ready.
- Reset mid-operation: in-flight operation is aborted and no response is issued; the FSM returns to IDLE immediately (asynchronously).
- Wrap-around: ADD/SUB results are modulo 2^W; carry is reported only via rsp_cout.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds output perf_ops[15:0], reset 0. It increments on every rsp_valid && rsp_ready handshake and wraps 0xFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg: op encodings (OP_AND, OP_OR, OP_ADD, OP_SUB), FSM state enum, NIBBLE_W = 4.
- Sub-module alu_nibble_slice: combinational 4-bit AND/OR/ADD; ports a, b, op, cin -> f, cout, c3 (carry into bit 3, used for overflow).
- alu_seq_ctrl holds the FSM, arbiter, registers and the single slice instance.

Test Plan:
1. WORDS=2, req0 ADD a=0x7F b=0x01 -> rsp_result 0x80, overflow 1, cout 0, zero 0, rsp_id 0; rsp_valid at accept+3.
2. req1 SUB a=0x05 b=0x05 -> rsp_result 0x00, zero 1, cout 1, overflow 0, rsp_id 1.
3. Both valid out of reset: req0 AND 0xF0&0x3C and req1 OR 0x0F|0xF0 -> req0 granted first (0x30, id 0), then req1 (0xFF, id 1); no double ready.
4. rsp_ready held low 5 cycles in DONE -> rsp_* unchanged, busy 1, both req ready 0; release -> IDLE next cycle.
5. rst_n pulsed low during EXEC -> rsp_valid/busy 0 immediately, no response issued; next req0 ADD 0x01+0x02 -> 0x03 normally.
6. ADD 0xFF+0x01 -> result 0x00, cout 1, zero 1, overflow 0; with ALU_SEQ_PERF_EN, perf_ops counts each completed handshake.
